// File: rtl/ov7670_capture.sv
// OV7670 capture: registers the RGB565 byte stream, decimates the frame and
// emits RGB222 write strobes into the frame buffer, all on the camera PCLK.
module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int DECIM_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [5:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = 10;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEC_MASK = CNT_W'((1 << DECIM_SHIFT) - 1);
  localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACTIVE);
  localparam int                NUM_PIX  = (H_ACTIVE >> DECIM_SHIFT) * (V_ACTIVE >> DECIM_SHIFT);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_PIX);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [7:0] d;
  } cam_s_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  state_t            state_q, state_d;
  cam_s_t            s1;
  logic              vs_prev, hr_prev, vs_rise_q;
  logic              vs_rise, vs_fall;
  logic              start, close;
  logic              phase_q;
  logic [7:0]        byte0_q;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              pix_keep;
  rgb565_t           pix;
  logic              unused_bits;

  // Input stage and edge history; everything downstream looks only at S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      vs_prev   <= 1'b0;
      hr_prev   <= 1'b0;
      vs_rise_q <= 1'b0;
    end else begin
      s1        <= '{vsync: cam_vsync, href: cam_href, d: cam_d};
      vs_prev   <= s1.vsync;
      hr_prev   <= s1.href;
      vs_rise_q <= vs_rise;
    end
  end

  assign vs_rise = s1.vsync & ~vs_prev;
  assign vs_fall = ~s1.vsync & vs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  // Frame close uses the delayed vsync edge so a coincident href fall is
  // already folded into y_cnt when frame_err is evaluated.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      SYNC:   if (s1.vsync) state_d = IDLE;
      IDLE:   if (vs_fall && enable) begin
                state_d = ACTIVE;
                start   = 1'b1;
              end
      ACTIVE: if (vs_rise_q) begin
                state_d = IDLE;
                close   = 1'b1;
              end
      default: state_d = SYNC;
    endcase
  end

  assign pix = rgb565_t'({byte0_q, s1.d});
  assign unused_bits = ^{pix.r[2:0], pix.g[3:0], pix.b[2:0]};

  assign pix_keep = (state_q == ACTIVE) && s1.href && phase_q &&
                    (x_cnt < H_LIM) && (y_cnt < V_LIM) &&
                    ((x_cnt & DEC_MASK) == '0) && ((y_cnt & DEC_MASK) == '0) &&
                    (addr_cnt < ADDR_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= 1'b0;
      byte0_q    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (start) begin
        phase_q  <= 1'b0;
        x_cnt    <= '0;
        y_cnt    <= '0;
        addr_cnt <= '0;
        wr_addr  <= '0;
      end else if (state_q == ACTIVE) begin
        if (s1.href) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            byte0_q <= s1.d;
          end else begin
            if (x_cnt != CNT_MAX) x_cnt <= x_cnt + CNT_ONE;
            if (pix_keep) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_cnt;
              wr_data  <= {pix.r[4:3], pix.g[5:4], pix.b[4:3]};
              addr_cnt <= addr_cnt + ADDR_ONE;
            end
          end
        end else if (hr_prev) begin
          // End of line: a dangling phase-0 byte is simply dropped here.
          phase_q <= 1'b0;
          x_cnt   <= '0;
          if (y_cnt != CNT_MAX) y_cnt <= y_cnt + CNT_ONE;
        end
        if (close) begin
          frame_done <= 1'b1;
          frame_err  <= (y_cnt != V_LIM);
        end
      end
    end
  end

  assign busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a reduced 32x16 sensor (8x4 output).
module tb_ov7670_capture;

  localparam int H = 32;
  localparam int V = 16;

  logic        clk, rst_n, enable, cam_vsync, cam_href;
  logic [7:0]  cam_d;
  logic        wr_en, frame_done, frame_err, busy;
  logic [14:0] wr_addr;
  logic [5:0]  wr_data;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_SHIFT(2), .ADDR_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_d(cam_d), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   wr_obs = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_px(input logic [7:0] a, input logic [7:0] c);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] bl;
    r  = a[7:3];
    g  = {a[2:0], c[7:5]};
    bl = c[4:0];
    return int'({r[4:3], g[5:4], bl[4:3]});
  endfunction

  // Output monitor: pops the scoreboard on every write strobe.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (wr_en) begin
      wr_obs++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("wr_cyc", cyc, e.cyc);
      end
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      last_err = int'(frame_err);
      chk("busy_at_done", int'(busy), 0);
    end else if (frame_err) begin
      chk("err_without_done", 1, 0);
    end
  end

  task automatic send_frame(input int lines, input int ppl, input int mode, input bit en_fall,
                            input int odd_line, input int rst_line, input int exp_wr,
                            input bit exp_done, input bit exp_err);
    bit         cap;
    int         nb, x, w_start, d_start, n_vs;
    logic [7:0] b0, b1;
    b0 = '0;
    @(negedge clk);
    cam_vsync = 1'b1; cam_href = 1'b0; enable = en_fall;
    repeat (8) @(negedge clk);
    cam_vsync = 1'b0;
    cap = en_fall; w_start = wr_obs; d_start = done_cnt;
    repeat (6) @(negedge clk);
    for (int y = 0; y < lines; y++) begin
      chk("busy", int'(busy), int'(cap));
      nb = 2 * ppl + ((y == odd_line) ? 1 : 0);
      for (int b = 0; b < nb; b++) begin
        x = b / 2;
        cam_href = 1'b1;
        if (b % 2 == 0) begin
          case (mode)
            1: b0 = 8'hF8;
            2: b0 = 8'h07;
            3: b0 = 8'h00;
            default: b0 = 8'($urandom);
          endcase
          cam_d = b0;
        end else begin
          case (mode)
            1: b1 = 8'h00;
            2: b1 = 8'hE0;
            3: b1 = 8'h1F;
            default: b1 = 8'($urandom);
          endcase
          cam_d = b1;
        end
        if (y == rst_line && b == 10) begin
          rst_n = 1'b0; cap = 1'b0;
          #1;
          chk("rst_wr_en", int'(wr_en), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_wr_addr", int'(wr_addr), 0);
          sb.delete();
          w_start = wr_obs;
        end
        if (y == rst_line && b == 14) rst_n = 1'b1;
        if (b % 2 == 1 && cap && x < H && y < V && x % 4 == 0 && y % 4 == 0)
          sb.push_back('{addr: (y / 4) * (H / 4) + x / 4, data: exp_px(b0, b1), cyc: cyc + 2});
        @(negedge clk);
      end
      cam_href = 1'b0;
      if (y == 0) enable = 1'b1;
      repeat (6) @(negedge clk);
    end
    cam_vsync = 1'b1;
    n_vs = cyc;
    repeat (8) @(negedge clk);
    chk("writes", wr_obs - w_start, exp_wr);
    chk("sb_left", sb.size(), 0);
    chk("frames", done_cnt - d_start, int'(exp_done));
    if (exp_done) begin
      chk("done_cyc", done_cyc, n_vs + 3);
      chk("frame_err", last_err, int'(exp_err));
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    // lines, ppl, mode, en_fall, odd_line, rst_line, exp_wr, exp_done, exp_err
    send_frame(16, 32, 1, 1'b1, -1, -1, 32, 1'b1, 1'b0);
    send_frame(16, 32, 0, 1'b1,  0, -1, 32, 1'b1, 1'b0);
    send_frame(16, 32, 2, 1'b1,  4, -1, 32, 1'b1, 1'b0);
    send_frame(16, 32, 0, 1'b0, -1, -1,  0, 1'b0, 1'b0);
    send_frame(16, 32, 3, 1'b1, -1, -1, 32, 1'b1, 1'b0);
    send_frame(12, 40, 0, 1'b1, -1, -1, 24, 1'b1, 1'b1);
    send_frame(20, 32, 0, 1'b1, -1, -1, 32, 1'b1, 1'b1);
    send_frame(16, 32, 0, 1'b1, -1,  5,  0, 1'b0, 1'b0);
    send_frame(16, 32, 0, 1'b1, -1, -1, 32, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
